// File: rtl/cordic_result_collector.sv
// Pairs CORDIC core results with issued mode tags, optionally applies gain
// compensation (macro CORDIC_GAIN_COMP_EN), and buffers results for a consumer.
module cordic_result_collector #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [2:0]  issue_mode,
  output logic        issue_ready,
  input  logic        res_valid,
  input  logic [31:0] res_x,
  input  logic [31:0] res_y,
  input  logic [31:0] res_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic [2:0]  out_mode,
  output logic [4:0]  inflight,
  output logic        err_orphan
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [2:0]    tag_mem_q [DEPTH];
  logic          tag_empty, issue_fire, res_take;

  logic [PW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [31:0]   ox_mem_q [DEPTH];
  logic [31:0]   oy_mem_q [DEPTH];
  logic [31:0]   oz_mem_q [DEPTH];
  logic [2:0]    om_mem_q [DEPTH];
  logic          out_empty, out_fire;

  logic          s1_vld_q, s1_vld_d;
  logic [2:0]    s1_mode_q, s1_mode_d;
  logic [31:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_z_q, s1_z_d;

  logic          wr_vld;
  logic [2:0]    wr_mode;
  logic [31:0]   wr_x, wr_y, wr_z;

  logic [4:0]    inflight_q, inflight_d;
  logic          err_orphan_q, err_orphan_d;

  assign issue_ready = (inflight_q < 5'(DEPTH));
  assign inflight    = inflight_q;
  assign err_orphan  = err_orphan_q;
  assign out_empty   = (out_wr_q == out_rd_q);
  assign out_valid   = !out_empty;

  // Show-ahead head entry, forced to zero while empty
  always_comb begin
    out_x    = '0;
    out_y    = '0;
    out_z    = '0;
    out_mode = '0;
    if (out_valid) begin
      out_x    = ox_mem_q[out_rd_q[AW-1:0]];
      out_y    = oy_mem_q[out_rd_q[AW-1:0]];
      out_z    = oz_mem_q[out_rd_q[AW-1:0]];
      out_mode = om_mem_q[out_rd_q[AW-1:0]];
    end
  end

  always_comb begin
    issue_fire   = issue_valid && issue_ready;
    tag_empty    = (tag_wr_q == tag_rd_q);
    res_take     = res_valid && !tag_empty;
    out_fire     = out_valid && out_ready;
    tag_wr_d     = tag_wr_q + PW'(issue_fire);
    tag_rd_d     = tag_rd_q + PW'(res_take);
    out_wr_d     = out_wr_q + PW'(wr_vld);
    out_rd_d     = out_rd_q + PW'(out_fire);
    err_orphan_d = err_orphan_q | (res_valid && tag_empty);
    s1_vld_d     = res_take;
    s1_mode_d    = tag_mem_q[tag_rd_q[AW-1:0]];
    s1_x_d       = res_x;
    s1_y_d       = res_y;
    s1_z_d       = res_z;
    inflight_d   = inflight_q;
    if (issue_fire && !out_fire) inflight_d = inflight_q + 5'd1;
    if (!issue_fire && out_fire) inflight_d = inflight_q - 5'd1;
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [31:0] K_CIRC = 32'd39796;
  localparam logic [31:0] K_HYP  = 32'd79137;

  logic        s2_vld_q, s2_vld_d;
  logic [2:0]  s2_mode_q, s2_mode_d;
  logic [31:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d, s2_z_q, s2_z_d;

  // Signed Q16.16 multiply; bits [47:16] equal the arithmetic >>16 truncated to 32
  function automatic logic [31:0] gain_mul(input logic [31:0] v, input logic [31:0] k);
    logic signed [63:0] prod;
    prod = $signed({{32{v[31]}}, v}) * $signed({32'd0, k});
    return prod[47:16];
  endfunction

  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_mode_d = s1_mode_q;
    s2_x_d    = s1_x_q;
    s2_y_d    = s1_y_q;
    s2_z_d    = s1_z_q;
    case (s1_mode_q[2:1])
      2'b00: begin
        s2_x_d = gain_mul(s1_x_q, K_CIRC);
        s2_y_d = gain_mul(s1_y_q, K_CIRC);
      end
      2'b10: begin
        s2_x_d = gain_mul(s1_x_q, K_HYP);
        s2_y_d = gain_mul(s1_y_q, K_HYP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) s2_vld_q <= 1'b0;
    else     s2_vld_q <= s2_vld_d;
    s2_mode_q <= s2_mode_d;
    s2_x_q    <= s2_x_d;
    s2_y_q    <= s2_y_d;
    s2_z_q    <= s2_z_d;
  end

  assign wr_vld  = s2_vld_q;
  assign wr_mode = s2_mode_q;
  assign wr_x    = s2_x_q;
  assign wr_y    = s2_y_q;
  assign wr_z    = s2_z_q;
`else
  assign wr_vld  = s1_vld_q;
  assign wr_mode = s1_mode_q;
  assign wr_x    = s1_x_q;
  assign wr_y    = s1_y_q;
  assign wr_z    = s1_z_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      s1_vld_q     <= 1'b0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      s1_vld_q     <= s1_vld_d;
      inflight_q   <= inflight_d;
      err_orphan_q <= err_orphan_d;
    end
    s1_mode_q <= s1_mode_d;
    s1_x_q    <= s1_x_d;
    s1_y_q    <= s1_y_d;
    s1_z_q    <= s1_z_d;
  end

  // Storage arrays need no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem_q[tag_wr_q[AW-1:0]] <= issue_mode;
    if (wr_vld) begin
      ox_mem_q[out_wr_q[AW-1:0]] <= wr_x;
      oy_mem_q[out_wr_q[AW-1:0]] <= wr_y;
      oz_mem_q[out_wr_q[AW-1:0]] <= wr_z;
      om_mem_q[out_wr_q[AW-1:0]] <= wr_mode;
    end
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Self-checking bench for cordic_result_collector: vector table plus scoreboard of popped results.
module tb_cordic_result_collector;
  localparam int unsigned DEPTH = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam bit GAIN = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit GAIN = 1'b0;
  localparam int LAT  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_mode = 3'd0;
  logic        issue_ready;
  logic        res_valid = 1'b0;
  logic [31:0] res_x = '0, res_y = '0, res_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x, out_y, out_z;
  logic [2:0]  out_mode;
  logic [4:0]  inflight;
  logic        err_orphan;

  cordic_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_mode(issue_mode), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_mode(out_mode),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } res_t;

  typedef struct {
    logic [2:0] mode;
    int rx, ry, rz;
    int cx, cy;
  } vec_t;

  res_t       exp_q[$];
  logic [2:0] tag_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Independent reference for the compensated value of one coordinate
  function automatic logic [31:0] comp(input logic [2:0] m, input logic [31:0] v);
    longint p;
    if (!GAIN) return v;
    if (m[2:1] == 2'b00)      p = longint'($signed(v)) * 39796;
    else if (m[2:1] == 2'b10) p = longint'($signed(v)) * 79137;
    else return v;
    return 32'(p >>> 16);
  endfunction

  // Scoreboard: every accepted pop is compared against the oldest expectation
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got mode %0d x %0d with empty scoreboard", out_mode, out_x);
      end else begin
        e = exp_q.pop_front();
        check("pop_mode", 32'(out_mode), 32'(e.mode));
        check("pop_x", out_x, e.x);
        check("pop_y", out_y, e.y);
        check("pop_z", out_z, e.z);
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    res_valid   = 1'b0;
  endtask

  task automatic do_issue(input logic [2:0] m);
    issue_valid = 1'b1;
    issue_mode  = m;
    tag_q.push_back(m);
  endtask

  task automatic do_res_exp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            input logic [31:0] ex, input logic [31:0] ey);
    res_t e;
    res_valid = 1'b1;
    res_x = x;
    res_y = y;
    res_z = z;
    if (tag_q.size() != 0) begin
      e.mode = tag_q.pop_front();
      e.x = ex;
      e.y = ey;
      e.z = z;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_res(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [2:0] m;
    m = (tag_q.size() != 0) ? tag_q[0] : 3'd0;
    do_res_exp(x, y, z, comp(m, x), comp(m, y));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tbl[9];
  logic [2:0] mix_modes[4];

  initial begin
    int lat, base, n;
    logic [31:0] ex, ey;

    tbl[0] = '{3'd0, 65536, -65536, 0, 39796, -39796};
    tbl[1] = '{3'd4, 65536, 0, 12345, 79137, 0};
    tbl[2] = '{3'd2, 0, 196608, 7, 0, 196608};
    tbl[3] = '{3'd1, 131072, 32768, -3, 79592, 19898};
    tbl[4] = '{3'd5, -131072, 196608, 42, -158274, 237411};
    tbl[5] = '{3'd3, -5, 123456, -99, -5, 123456};
    tbl[6] = '{3'd0, -1, 1, 1, -1, 0};
    tbl[7] = '{3'd7, 2147483647, 32'sh8000_0000, 0, 2147483647, 32'sh8000_0000};
    tbl[8] = '{3'd4, 2147483647, -65536, 5, -1701806082, -79137};
    mix_modes[0] = 3'd0;
    mix_modes[1] = 3'd3;
    mix_modes[2] = 3'd5;
    mix_modes[3] = 3'd1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_x", out_x, 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);
    rst = 1'b0;
    tick();

    // Single result latency from res_valid to out_valid
    do_issue(3'd0);
    tick();
    idle();
    do_res(32'h0001_0000, 32'hFFFF_0000, 32'd0);
    tick();
    idle();
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("lat_inflight", 32'(inflight), 32'd1);
    wait_drain("latency");
    check("lat_inflight_after", 32'(inflight), 32'd0);

    // Vector table: issue i and return result i-1 in the same cycle
    out_ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      idle();
      if (i < 9) do_issue(tbl[i].mode);
      if (i > 0) begin
        ex = GAIN ? tbl[i-1].cx : tbl[i-1].rx;
        ey = GAIN ? tbl[i-1].cy : tbl[i-1].ry;
        do_res_exp(tbl[i-1].rx, tbl[i-1].ry, tbl[i-1].rz, ex, ey);
      end
      tick();
    end
    idle();
    wait_drain("table");

    // Credit exhaustion and release
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_issue(3'(i));
      tick();
    end
    idle();
    check("full_issue_ready", 32'(issue_ready), 32'd0);
    check("full_inflight", 32'(inflight), 32'd8);
    for (int i = 0; i < 8; i++) begin
      idle();
      do_res(32'((i + 1) * 65536), 32'(-(i * 1000)), 32'(i));
      tick();
    end
    idle();
    for (int i = 0; i < LAT + 1; i++) tick();
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_issue_ready_hold", 32'(issue_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_issue_ready", 32'(issue_ready), 32'd1);
    check("release_inflight", 32'(inflight), 32'd7);
    wait_drain("credit");
    check("credit_inflight_after", 32'(inflight), 32'd0);

    // Orphan result
    out_ready = 1'b0;
    do_res(32'd11, 32'd22, 32'd33);
    tick();
    idle();
    check("orphan_flag", 32'(err_orphan), 32'd1);
    check("orphan_inflight", 32'(inflight), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("orphan_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("orphan_cleared", 32'(err_orphan), 32'd0);

    // Mixed modes back-to-back with out_ready toggling every cycle
    base = n_pop;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c < 4) do_issue(mix_modes[c]);
      if (c >= 2 && c < 6) do_res(32'((c - 1) * 65536), 32'(-((c - 1) * 4096)), 32'(c * 100));
      tick();
      out_ready = ~out_ready;
    end
    idle();
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      tick();
      out_ready = ~out_ready;
      n++;
    end
    check("mix_pops", 32'(n_pop - base), 32'd4);
    check("mix_drained", 32'(exp_q.size()), 32'd0);

    // Reset with results buffered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_issue(3'd2);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      idle();
      do_res(32'(i), 32'(i + 1), 32'(i + 2));
      tick();
    end
    idle();
    for (int i = 0; i < LAT + 1; i++) tick();
    check("buf_out_valid", 32'(out_valid), 32'd1);
    check("buf_inflight", 32'(inflight), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_inflight", 32'(inflight), 32'd0);
    check("midrst_issue_ready", 32'(issue_ready), 32'd1);
    check("midrst_out_y", out_y, 32'd0);
    do_res(32'd5, 32'd6, 32'd7);
    tick();
    idle();
    for (int i = 0; i < LAT + 1; i++) tick();
    check("post_rst_orphan", 32'(err_orphan), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_result_collector.md
CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

Interface
REQ-001 The block SHALL have exactly one parameter: DEPTH, default 8, in-flight/output buffer entries; power of two, 2..16.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  a request is being presented to the CORDIC core this cycle.
- issue_mode  in  3  mode of that request (000..101).
- issue_ready  out  1  credit available; the upstream issuer SHALL NOT assert issue_valid while this is low.
- res_valid  in  1  post_valid from the CORDIC core.
- res_x, res_y, res_z  in  32 each  signed Q16.16 core outputs.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_x, out_y, out_z  out  32 each  signed Q16.16 compensated result.
- out_mode  out  3  mode tag of the head entry.
- inflight  out  5  outstanding count (issued and not yet popped).
- err_orphan  out  1  sticky flag: a result arrived with no matching tag.

Function
REQ-003 An issue is accepted when issue_valid && issue_ready; issue_mode SHALL then be pushed into a DEPTH-entry tag FIFO.
REQ-004 On res_valid, the block SHALL pop the tag FIFO head and pair it with res_x/res_y/res_z in order; the core returns results in issue order.
REQ-005 If res_valid arrives with the tag FIFO empty, the block SHALL drop the result, set err_orphan, and leave inflight unchanged.
REQ-006 Gain compensation:
- Modes 000 and 001: x and y SHALL be multiplied by K = 39796 (0.607253 in Q16).
- Modes 100 and 101: x and y SHALL be multiplied by K_h = 79137 (1.207534 in Q16).
- Multiply SHALL be signed, 64-bit, arithmetic right shift by 16, truncated to 32 bits.
- z SHALL always pass through unchanged.
- Modes 010, 011, 110 and 111 SHALL pass x and y through unchanged.
REQ-007 Compensation SHALL be one register stage; a result SHALL be written to the output FIFO 2 cycles after its res_valid cycle.
REQ-008 The output FIFO SHALL be DEPTH entries and show-ahead:
- out_valid = not empty.
- out_* SHALL reflect the head entry.
- out_* SHALL be 0 when empty.
- A pop occurs on out_valid && out_ready.
REQ-009 The inflight counter SHALL update as follows:
- Increment on accepted issue.
- Decrement on pop.
- Unchanged when both occur in the same cycle.
- issue_ready = (inflight < DEPTH), a combinational decode of the counter register.
REQ-010 The credit scheme guarantees that the output FIFO and the tag FIFO can never overflow; there is no backpressure to the core.
REQ-011 The block SHALL accept a write and a pop on the output FIFO in the same cycle, including when the FIFO is full (the pop frees the entry first) and when it is empty (the write-then-read occurs on the following cycle).
REQ-012 FIFO pointers SHALL wrap modulo DEPTH with an extra wrap bit for full/empty detection.

Reset
REQ-013 While rst is high at a clock edge, the block SHALL:
- Clear all FIFO pointers, inflight, the compensation stage valid bit and err_orphan.
- Drive out_valid=0, out_x=out_y=out_z=0, out_mode=0 and issue_ready=1.
REQ-014 Reset mid-operation SHALL discard all pending tags and results; any core results arriving after reset SHALL be treated per REQ-005.

Configuration
REQ-015 Macro CORDIC_GAIN_COMP_EN:
- When defined: REQ-006 and REQ-007 apply.
- When undefined: no multipliers are built, x/y/z pass through for all modes, and results are written to the output FIFO 1 cycle after res_valid.
- Tag, credit and FIFO behaviour SHALL be identical in both cases.

Verification
REQ-016 Issue mode 000, then res_x=65536, res_y=-65536 -> out_x=39796, out_y=-39796, out_mode=000; out_valid rises 3 cycles after res_valid with CORDIC_GAIN_COMP_EN.
REQ-017 Issue mode 100, res_x=65536, res_z=12345 -> out_x=79137, out_z=12345; issue mode 010, res_y=196608 -> out_y=196608.
REQ-018 out_ready=0, issue 8 requests -> issue_ready=0 after the 8th and inflight=8; pop one -> issue_ready=1 on the next cycle.
REQ-019 res_valid with no prior issue -> err_orphan=1, out_valid stays 0, inflight=0; assert rst -> err_orphan=0.
REQ-020 Mixed modes 000, 011, 101, 001 issued back-to-back, results returned back-to-back with out_ready toggling every cycle -> popped order and mode tags match issue order, with no loss or duplication.
REQ-021 Assert rst while 4 results are buffered -> next cycle out_valid=0, inflight=0, issue_ready=1.
